// File: rtl/ysyx_23060184_xbar.sv
// AXI4-Lite 1-to-2 crossbar: routes one outstanding transaction to SRAM or UART by address, DECERR otherwise.
// Optional watchdog enabled by defining XBAR_TIMEOUT_EN.
module ysyx_23060184_xbar #(
  parameter logic [31:0] SRAM_BASE  = 32'h8000_0000,
  parameter logic [31:0] SRAM_LIMIT = 32'h87FF_FFFF,
  parameter logic [31:0] UART_BASE  = 32'hA000_03F8,
  parameter logic [31:0] UART_LIMIT = 32'hA000_03FF
`ifdef XBAR_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic        clk,
  input  logic        resetn,
  // master port
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  // SRAM slave port
  output logic [31:0] s_araddr,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rvalid,
  output logic        s_rready,
  output logic [31:0] s_awaddr,
  output logic        s_awvalid,
  input  logic        s_awready,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic        s_wvalid,
  input  logic        s_wready,
  input  logic [1:0]  s_bresp,
  input  logic        s_bvalid,
  output logic        s_bready,
  // UART slave port
  output logic [31:0] u_araddr,
  output logic        u_arvalid,
  input  logic        u_arready,
  input  logic [31:0] u_rdata,
  input  logic [1:0]  u_rresp,
  input  logic        u_rvalid,
  output logic        u_rready,
  output logic [31:0] u_awaddr,
  output logic        u_awvalid,
  input  logic        u_awready,
  output logic [31:0] u_wdata,
  output logic [3:0]  u_wstrb,
  output logic        u_wvalid,
  input  logic        u_wready,
  input  logic [1:0]  u_bresp,
  input  logic        u_bvalid,
  output logic        u_bready
);

  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE, RD, WR, RERR_A, RERR_D, WERR_A, WERR_B
  } state_e;

  typedef enum logic [1:0] {TGT_NONE, TGT_SRAM, TGT_UART} tgt_e;

  state_e r_state, w_state_n;
  tgt_e   r_tgt, w_tgt_n;
  logic   r_aw_done, r_w_done, w_aw_done_n, w_w_done_n;
  logic   w_to;

  // SRAM wins if the two windows ever overlap
  function automatic tgt_e decode(input logic [31:0] a);
    if (a >= SRAM_BASE && a <= SRAM_LIMIT)      decode = TGT_SRAM;
    else if (a >= UART_BASE && a <= UART_LIMIT) decode = TGT_UART;
    else                                        decode = TGT_NONE;
  endfunction

`ifdef XBAR_TIMEOUT_EN
  logic [7:0] r_cnt;

  // Counter is held at zero outside RD/WR and saturates at the limit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= 8'd0;
    end else if (r_state != RD && r_state != WR) begin
      r_cnt <= 8'd0;
    end else if (!w_to) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign w_to = (r_cnt == 8'(TIMEOUT_CYCLES));
`else
  assign w_to = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_tgt     <= TGT_NONE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_tgt     <= w_tgt_n;
      r_aw_done <= w_aw_done_n;
      r_w_done  <= w_w_done_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_tgt_n     = r_tgt;
    w_aw_done_n = r_aw_done;
    w_w_done_n  = r_w_done;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    s_araddr = 32'd0; s_arvalid = 1'b0; s_rready = 1'b0;
    s_awaddr = 32'd0; s_awvalid = 1'b0; s_wdata = 32'd0; s_wstrb = 4'd0;
    s_wvalid = 1'b0; s_bready = 1'b0;
    u_araddr = 32'd0; u_arvalid = 1'b0; u_rready = 1'b0;
    u_awaddr = 32'd0; u_awvalid = 1'b0; u_wdata = 32'd0; u_wstrb = 4'd0;
    u_wvalid = 1'b0; u_bready = 1'b0;

    case (r_state)
      IDLE: begin
        if (arvalid) begin
          w_tgt_n   = decode(araddr);
          w_state_n = (w_tgt_n == TGT_NONE) ? RERR_A : RD;
        end else if (awvalid) begin
          w_tgt_n   = decode(awaddr);
          w_state_n = (w_tgt_n == TGT_NONE) ? WERR_A : WR;
        end
      end

      RD: begin
        if (w_to) begin
          rvalid = 1'b1;
          rresp  = RESP_SLVERR;
        end else if (r_tgt == TGT_SRAM) begin
          s_araddr  = araddr;
          s_arvalid = arvalid;
          arready   = s_arready;
          s_rready  = rready;
          rvalid    = s_rvalid;
          rdata     = s_rvalid ? s_rdata : 32'd0;
          rresp     = s_rvalid ? s_rresp : 2'b00;
        end else if (r_tgt == TGT_UART) begin
          u_araddr  = araddr;
          u_arvalid = arvalid;
          arready   = u_arready;
          u_rready  = rready;
          rvalid    = u_rvalid;
          rdata     = u_rvalid ? u_rdata : 32'd0;
          rresp     = u_rvalid ? u_rresp : 2'b00;
        end
        if (rvalid && rready) begin
          w_state_n = IDLE;
          w_tgt_n   = TGT_NONE;
        end
      end

      WR: begin
        if (w_to) begin
          bvalid = 1'b1;
          bresp  = RESP_SLVERR;
        end else if (r_tgt == TGT_SRAM) begin
          s_awaddr  = awaddr;
          s_awvalid = awvalid;
          awready   = s_awready;
          s_wdata   = wdata;
          s_wstrb   = wstrb;
          s_wvalid  = wvalid;
          wready    = s_wready;
          s_bready  = bready;
          bvalid    = s_bvalid;
          bresp     = s_bvalid ? s_bresp : 2'b00;
        end else if (r_tgt == TGT_UART) begin
          u_awaddr  = awaddr;
          u_awvalid = awvalid;
          awready   = u_awready;
          u_wdata   = wdata;
          u_wstrb   = wstrb;
          u_wvalid  = wvalid;
          wready    = u_wready;
          u_bready  = bready;
          bvalid    = u_bvalid;
          bresp     = u_bvalid ? u_bresp : 2'b00;
        end
        if (bvalid && bready) begin
          w_state_n = IDLE;
          w_tgt_n   = TGT_NONE;
        end
      end

      RERR_A: begin
        arready   = 1'b1;
        w_state_n = RERR_D;
      end

      RERR_D: begin
        rvalid = 1'b1;
        rresp  = RESP_DECERR;
        if (rready) begin
          w_state_n = IDLE;
          w_tgt_n   = TGT_NONE;
        end
      end

      // aw and w may complete in any order; each flag remembers its handshake
      WERR_A: begin
        awready     = 1'b1;
        wready      = 1'b1;
        w_aw_done_n = r_aw_done | awvalid;
        w_w_done_n  = r_w_done | wvalid;
        if (w_aw_done_n && w_w_done_n) begin
          w_state_n   = WERR_B;
          w_aw_done_n = 1'b0;
          w_w_done_n  = 1'b0;
        end
      end

      WERR_B: begin
        bvalid = 1'b1;
        bresp  = RESP_DECERR;
        if (bready) begin
          w_state_n = IDLE;
          w_tgt_n   = TGT_NONE;
        end
      end

      default: begin
        w_state_n = IDLE;
        w_tgt_n   = TGT_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060184_xbar.sv
// Directed bench for ysyx_23060184_xbar: routing, DECERR paths, priority, mid-transaction reset, optional watchdog.
module tb_ysyx_23060184_xbar;

  logic        clk, resetn;
  logic [31:0] araddr, awaddr, wdata;
  logic        arvalid, awvalid, wvalid, rready, bready;
  logic [3:0]  wstrb;
  logic        arready, awready, wready, rvalid, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  logic [31:0] s_araddr, s_awaddr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready;
  logic        s_arready, s_awready, s_wready, s_rvalid, s_bvalid;
  logic [1:0]  s_rresp, s_bresp;

  logic [31:0] u_araddr, u_awaddr, u_wdata, u_rdata;
  logic [3:0]  u_wstrb;
  logic        u_arvalid, u_awvalid, u_wvalid, u_rready, u_bready;
  logic        u_arready, u_awready, u_wready, u_rvalid, u_bvalid;
  logic [1:0]  u_rresp, u_bresp;

  int total = 0;
  int bad   = 0;

  ysyx_23060184_xbar dut (
    .clk(clk), .resetn(resetn),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .u_araddr(u_araddr), .u_arvalid(u_arvalid), .u_arready(u_arready),
    .u_rdata(u_rdata), .u_rresp(u_rresp), .u_rvalid(u_rvalid), .u_rready(u_rready),
    .u_awaddr(u_awaddr), .u_awvalid(u_awvalid), .u_awready(u_awready),
    .u_wdata(u_wdata), .u_wstrb(u_wstrb), .u_wvalid(u_wvalid), .u_wready(u_wready),
    .u_bresp(u_bresp), .u_bvalid(u_bvalid), .u_bready(u_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    araddr = 32'd0; arvalid = 1'b0; rready = 1'b0;
    awaddr = 32'd0; awvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0; wvalid = 1'b0; bready = 1'b0;
    s_arready = 1'b0; s_rdata = 32'd0; s_rresp = 2'b00; s_rvalid = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = 2'b00; s_bvalid = 1'b0;
    u_arready = 1'b0; u_rdata = 32'd0; u_rresp = 2'b00; u_rvalid = 1'b0;
    u_awready = 1'b0; u_wready = 1'b0; u_bresp = 2'b00; u_bvalid = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
    #12;
    total++; if ({arready, awready, wready, rvalid, bvalid} !== 5'b0) begin bad++; $display("FAIL reset_readys got=%b exp=00000", {arready, awready, wready, rvalid, bvalid}); end
    total++; if (rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=00000000", rdata); end
    total++; if ({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready, u_arvalid, u_awvalid, u_wvalid, u_rready, u_bready} !== 10'b0) begin bad++; $display("FAIL reset_slave_ctl got=%b exp=0", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready, u_arvalid, u_awvalid, u_wvalid, u_rready, u_bready}); end
    clear_inputs();
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_sram_read();
    araddr = 32'h8000_0010; arvalid = 1'b1; rready = 1'b1;
    #1;
    total++; if (s_arvalid !== 1'b0) begin bad++; $display("FAIL rd_decode_cycle s_arvalid got=%b exp=0", s_arvalid); end
    tick();
    s_arready = 1'b1;
    #1;
    total++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0010) begin bad++; $display("FAIL rd_s_ar got=%b/%h exp=1/80000010", s_arvalid, s_araddr); end
    total++; if (arready !== 1'b1) begin bad++; $display("FAIL rd_arready got=%b exp=1", arready); end
    total++; if (u_arvalid !== 1'b0) begin bad++; $display("FAIL rd_u_arvalid got=%b exp=0", u_arvalid); end
    tick();
    arvalid = 1'b0; s_arready = 1'b0;
    tick();
    tick();
    total++; if (rvalid !== 1'b0 || rdata !== 32'd0) begin bad++; $display("FAIL rd_wait got=%b/%h exp=0/00000000", rvalid, rdata); end
    s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b00;
    #1;
    total++; if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF || rresp !== 2'b00) begin bad++; $display("FAIL rd_data got=%b/%h/%b exp=1/deadbeef/00", rvalid, rdata, rresp); end
    total++; if (s_rready !== 1'b1 || u_rready !== 1'b0) begin bad++; $display("FAIL rd_rready got=%b/%b exp=1/0", s_rready, u_rready); end
    tick();
    #1;
    total++; if (rvalid !== 1'b0 || s_rready !== 1'b0) begin bad++; $display("FAIL rd_back_idle got=%b/%b exp=0/0", rvalid, s_rready); end
    clear_inputs();
    tick();
  endtask

  task automatic test_uart_write();
    awaddr = 32'hA000_03F8; awvalid = 1'b1; wdata = 32'h41; wstrb = 4'b0001; wvalid = 1'b1; bready = 1'b1;
    tick();
    u_awready = 1'b1; u_wready = 1'b1;
    #1;
    total++; if (u_awvalid !== 1'b1 || u_wvalid !== 1'b1 || u_awaddr !== 32'hA000_03F8) begin bad++; $display("FAIL wr_u_aw_w got=%b/%b/%h exp=1/1/a00003f8", u_awvalid, u_wvalid, u_awaddr); end
    total++; if (u_wdata !== 32'h41 || u_wstrb !== 4'b0001) begin bad++; $display("FAIL wr_u_data got=%h/%b exp=00000041/0001", u_wdata, u_wstrb); end
    total++; if (awready !== 1'b1 || wready !== 1'b1) begin bad++; $display("FAIL wr_readys got=%b/%b exp=1/1", awready, wready); end
    total++; if ({s_awvalid, s_wvalid, s_bready} !== 3'b0) begin bad++; $display("FAIL wr_no_sram got=%b exp=000", {s_awvalid, s_wvalid, s_bready}); end
    tick();
    awvalid = 1'b0; wvalid = 1'b0; u_awready = 1'b0; u_wready = 1'b0;
    u_bvalid = 1'b1; u_bresp = 2'b00;
    #1;
    total++; if (bvalid !== 1'b1 || bresp !== 2'b00 || u_bready !== 1'b1) begin bad++; $display("FAIL wr_b got=%b/%b/%b exp=1/00/1", bvalid, bresp, u_bready); end
    tick();
    u_bvalid = 1'b0;
    #1;
    total++; if (bvalid !== 1'b0 || u_bready !== 1'b0) begin bad++; $display("FAIL wr_back_idle got=%b/%b exp=0/0", bvalid, u_bready); end
    clear_inputs();
    tick();
  endtask

  task automatic test_sram_write_limit();
    awaddr = 32'h87FF_FFFF; awvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'b1100; bready = 1'b1;
    tick();
    s_awready = 1'b1;
    #1;
    total++; if (s_awvalid !== 1'b1 || s_wvalid !== 1'b0 || u_awvalid !== 1'b0) begin bad++; $display("FAIL wl_aw got=%b/%b/%b exp=1/0/0", s_awvalid, s_wvalid, u_awvalid); end
    tick();
    awvalid = 1'b0; s_awready = 1'b0; wvalid = 1'b1; s_wready = 1'b1;
    #1;
    total++; if (s_wvalid !== 1'b1 || s_wdata !== 32'hCAFE_F00D || s_wstrb !== 4'b1100 || wready !== 1'b1) begin bad++; $display("FAIL wl_w got=%b/%h/%b/%b exp=1/cafef00d/1100/1", s_wvalid, s_wdata, s_wstrb, wready); end
    tick();
    wvalid = 1'b0; s_wready = 1'b0; s_bvalid = 1'b1; s_bresp = 2'b01;
    #1;
    total++; if (bvalid !== 1'b1 || bresp !== 2'b01) begin bad++; $display("FAIL wl_b got=%b/%b exp=1/01", bvalid, bresp); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_decerr_read();
    araddr = 32'h0000_0000; arvalid = 1'b1; rready = 1'b0;
    #1;
    total++; if (arready !== 1'b0) begin bad++; $display("FAIL derr_rd_idle arready got=%b exp=0", arready); end
    tick();
    total++; if (arready !== 1'b1 || rvalid !== 1'b0) begin bad++; $display("FAIL derr_rd_a got=%b/%b exp=1/0", arready, rvalid); end
    total++; if (s_arvalid !== 1'b0 || u_arvalid !== 1'b0) begin bad++; $display("FAIL derr_rd_noslave got=%b/%b exp=0/0", s_arvalid, u_arvalid); end
    tick();
    arvalid = 1'b0;
    #1;
    total++; if (rvalid !== 1'b1 || rresp !== 2'b11 || rdata !== 32'd0 || arready !== 1'b0) begin bad++; $display("FAIL derr_rd_d got=%b/%b/%h/%b exp=1/11/00000000/0", rvalid, rresp, rdata, arready); end
    tick();
    total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL derr_rd_hold got=%b exp=1", rvalid); end
    rready = 1'b1;
    tick();
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL derr_rd_done got=%b exp=0", rvalid); end
    clear_inputs();
    tick();
  endtask

  task automatic test_decerr_write();
    awaddr = 32'hA000_0400; awvalid = 1'b1; bready = 1'b0;
    tick();
    total++; if (awready !== 1'b1 || wready !== 1'b1 || u_awvalid !== 1'b0) begin bad++; $display("FAIL derr_wr_a got=%b/%b/%b exp=1/1/0", awready, wready, u_awvalid); end
    tick();
    awvalid = 1'b0; wvalid = 1'b1;
    #1;
    total++; if (bvalid !== 1'b0 || wready !== 1'b1) begin bad++; $display("FAIL derr_wr_waitw got=%b/%b exp=0/1", bvalid, wready); end
    tick();
    wvalid = 1'b0;
    #1;
    total++; if (bvalid !== 1'b1 || bresp !== 2'b11 || awready !== 1'b0) begin bad++; $display("FAIL derr_wr_b got=%b/%b/%b exp=1/11/0", bvalid, bresp, awready); end
    bready = 1'b1;
    tick();
    total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL derr_wr_done got=%b exp=0", bvalid); end
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    araddr = 32'h8000_0000; arvalid = 1'b1; rready = 1'b1;
    awaddr = 32'hA000_03FF; awvalid = 1'b1; wvalid = 1'b1; wdata = 32'h5A; wstrb = 4'b0001; bready = 1'b1;
    tick();
    s_arready = 1'b1;
    #1;
    total++; if (s_arvalid !== 1'b1 || u_awvalid !== 1'b0 || awready !== 1'b0) begin bad++; $display("FAIL b2b_read_first got=%b/%b/%b exp=1/0/0", s_arvalid, u_awvalid, awready); end
    tick();
    arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0BAD_F00D;
    #1;
    total++; if (rvalid !== 1'b1 || rdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL b2b_rdata got=%b/%h exp=1/0badf00d", rvalid, rdata); end
    tick();
    s_rvalid = 1'b0;
    #1;
    total++; if (u_awvalid !== 1'b0 || rvalid !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b/%b exp=0/0", u_awvalid, rvalid); end
    tick();
    u_awready = 1'b1; u_wready = 1'b1;
    #1;
    total++; if (u_awvalid !== 1'b1 || u_wvalid !== 1'b1 || u_awaddr !== 32'hA000_03FF) begin bad++; $display("FAIL b2b_write got=%b/%b/%h exp=1/1/a00003ff", u_awvalid, u_wvalid, u_awaddr); end
    tick();
    awvalid = 1'b0; wvalid = 1'b0; u_awready = 1'b0; u_wready = 1'b0; u_bvalid = 1'b1;
    #1;
    total++; if (bvalid !== 1'b1) begin bad++; $display("FAIL b2b_b got=%b exp=1", bvalid); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    araddr = 32'h8000_0100; arvalid = 1'b1; rready = 1'b1;
    tick();
    s_arready = 1'b1;
    #1;
    total++; if (s_arvalid !== 1'b1) begin bad++; $display("FAIL rst_mid_pre got=%b exp=1", s_arvalid); end
    #2;
    resetn = 1'b0;
    #1;
    total++; if (s_arvalid !== 1'b0 || arready !== 1'b0 || s_rready !== 1'b0) begin bad++; $display("FAIL rst_mid_drop got=%b/%b/%b exp=0/0/0", s_arvalid, arready, s_rready); end
    clear_inputs();
    @(negedge clk);
    resetn = 1'b1;
    tick();
    araddr = 32'h8000_0200; arvalid = 1'b1; rready = 1'b1;
    tick();
    s_arready = 1'b1;
    #1;
    total++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h8000_0200) begin bad++; $display("FAIL rst_mid_again got=%b/%h exp=1/80000200", s_arvalid, s_araddr); end
    tick();
    arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0000_00A5; s_rresp = 2'b00;
    #1;
    total++; if (rvalid !== 1'b1 || rdata !== 32'h0000_00A5) begin bad++; $display("FAIL rst_mid_rdata got=%b/%h exp=1/000000a5", rvalid, rdata); end
    tick();
    clear_inputs();
    tick();
  endtask

`ifdef XBAR_TIMEOUT_EN
  task automatic test_timeout();
    int cycles;
    araddr = 32'h8000_0040; arvalid = 1'b1; rready = 1'b0;
    tick();
    s_arready = 1'b1;
    tick();
    arvalid = 1'b0; s_arready = 1'b0;
    cycles = 1;
    #1;
    while (!rvalid && cycles < 400) begin
      tick();
      cycles++;
    end
    total++; if (cycles !== 255) begin bad++; $display("FAIL to_latency got=%0d exp=255", cycles); end
    total++; if (rvalid !== 1'b1 || rresp !== 2'b10 || rdata !== 32'd0) begin bad++; $display("FAIL to_resp got=%b/%b/%h exp=1/10/00000000", rvalid, rresp, rdata); end
    total++; if (s_arvalid !== 1'b0 || s_rready !== 1'b0) begin bad++; $display("FAIL to_slave got=%b/%b exp=0/0", s_arvalid, s_rready); end
    rready = 1'b1;
    tick();
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL to_done got=%b exp=0", rvalid); end
    clear_inputs();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_sram_read();
    test_uart_write();
    test_sram_write_limit();
    test_decerr_read();
    test_decerr_write();
    test_back_to_back();
    test_reset_mid();
`ifdef XBAR_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
